// File: rtl/motor_ramp_sequencer.sv
// Soft-start ramp and safe direction-reversal sequencer sitting between the
// processor set point registers and the PWM on-time / direction datapath.
module motor_ramp_sequencer #(
    parameter int CLOCK_FREQ_HZ       = 100_000_000,
    parameter int MAX_ON_TIME         = 10_000,
    parameter int RAMP_STEP           = 50,
    parameter int RAMP_TICK_CYCLES    = 100_000,
    parameter int STOP_TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] target_on_in,
    input  logic        target_dir_in,
    input  logic        enable_in,
    input  logic        motor_is_running,
    output logic [31:0] on_time_out,
    output logic        motor_dir_out,
    output logic [1:0]  state_out,
    output logic        busy_out,
    output logic        fault_out
);

    localparam int TICK_W = $clog2(RAMP_TICK_CYCLES + 1);
    localparam int TOUT_W = $clog2(STOP_TIMEOUT_CYCLES + 1);

    localparam logic [31:0]       MAX_ON    = 32'(MAX_ON_TIME);
    localparam logic [31:0]       STEP      = 32'(RAMP_STEP);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_TICK_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(STOP_TIMEOUT_CYCLES - 1);

    if (RAMP_TICK_CYCLES < 2 || STOP_TIMEOUT_CYCLES < 1 || CLOCK_FREQ_HZ < 1) begin : g_param_check
        $error("motor_ramp_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DECEL     = 2'd1,
        ST_WAIT_STOP = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cur_q, cur_d;
    logic                dir_q, dir_d;
    logic                busy_q, busy_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TOUT_W-1:0]   timeout_q, timeout_d;

    logic                tick;
    logic [31:0]         tgt;
    logic [31:0]         eff;
    logic [31:0]         goal;
    logic [31:0]         diff;
    logic [31:0]         ramped;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Differences are taken before adding so the step can never wrap past 2^32.
    always_comb begin
        tgt    = (target_on_in > MAX_ON) ? MAX_ON : target_on_in;
        eff    = enable_in ? tgt : '0;
        goal   = (state_q == ST_RUN) ? eff : '0;
        diff   = '0;
        ramped = cur_q;
        if (tick) begin
            if (cur_q < goal) begin
                diff   = goal - cur_q;
                ramped = cur_q + ((diff > STEP) ? STEP : diff);
            end else if (cur_q > goal) begin
                diff   = cur_q - goal;
                ramped = cur_q - ((diff > STEP) ? STEP : diff);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = ramped;
        dir_d     = dir_q;
        timeout_d = '0;
        case (state_q)
            ST_RUN: begin
                if (target_dir_in != dir_q) begin
                    if (cur_q != '0) begin
                        state_d = ST_DECEL;
                    end else begin
                        state_d = ST_WAIT_STOP;
                        cur_d   = '0;
                    end
                end
            end
            ST_DECEL: begin
                if (target_dir_in == dir_q) begin
                    state_d = ST_RUN;
                end else if (cur_q == '0) begin
                    state_d = ST_WAIT_STOP;
                end
            end
            ST_WAIT_STOP: begin
                cur_d = '0;
                if (target_dir_in == dir_q) begin
                    state_d = ST_RUN;
                end else if (!motor_is_running) begin
                    dir_d   = target_dir_in;
                    state_d = ST_RUN;
                end else if (timeout_q == TOUT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    timeout_d = timeout_q + TOUT_W'(1);
                end
            end
            ST_FAULT: begin
                cur_d = '0;
                if (!enable_in) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cur_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_RUN) || (cur_d != eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            cur_q      <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            tick_cnt_q <= '0;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            tick_cnt_q <= tick_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign on_time_out   = cur_q;
    assign motor_dir_out = dir_q;
    assign state_out     = state_q;
    assign busy_out      = busy_q;
    assign fault_out     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed vector table, hand-written reversal
// and reset sequences, then random stimulus against a behavioural model.
module tb_motor_ramp_sequencer;

    localparam int MAX_ON = 1000;
    localparam int STEP   = 100;
    localparam int TICK   = 4;
    localparam int STOP   = 50;

    localparam int S_RUN   = 0;
    localparam int S_DECEL = 1;
    localparam int S_WAIT  = 2;
    localparam int S_FAULT = 3;

    logic        clk;
    logic        reset;
    logic [31:0] target_on_in;
    logic        target_dir_in;
    logic        enable_in;
    logic        motor_is_running;
    logic [31:0] on_time_out;
    logic        motor_dir_out;
    logic [1:0]  state_out;
    logic        busy_out;
    logic        fault_out;

    int checks = 0;
    int errors = 0;

    longint m_cur;
    bit     m_dir;
    int     m_state;
    bit     m_busy;
    int     m_edges;
    int     m_wait;

    typedef struct {
        logic [31:0] target;
        bit          dir;
        bit          en;
        bit          run;
        int          cycles;
        int          exp_on;
        int          exp_state;
        bit          exp_dir;
        bit          exp_busy;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[$];

    motor_ramp_sequencer #(
        .CLOCK_FREQ_HZ      (100_000_000),
        .MAX_ON_TIME        (MAX_ON),
        .RAMP_STEP          (STEP),
        .RAMP_TICK_CYCLES   (TICK),
        .STOP_TIMEOUT_CYCLES(STOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .target_on_in    (target_on_in),
        .target_dir_in   (target_dir_in),
        .enable_in       (enable_in),
        .motor_is_running(motor_is_running),
        .on_time_out     (on_time_out),
        .motor_dir_out   (motor_dir_out),
        .state_out       (state_out),
        .busy_out        (busy_out),
        .fault_out       (fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void cmp(string name, string field, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s %s got %0d expected %0d", name, field, got, want);
        end
    endfunction

    function automatic void addVec(logic [31:0] t, bit d, bit e, bit r, int c,
                                   int on, int st, bit dout, bit b, bit f);
        vecs.push_back('{t, d, e, r, c, on, st, dout, b, f});
    endfunction

    function automatic longint towards(longint cur, longint goal);
        longint d;
        d = goal - cur;
        if (d > STEP) d = STEP;
        else if (d < -STEP) d = -STEP;
        return cur + d;
    endfunction

    function automatic void modelReset();
        m_cur   = 0;
        m_dir   = 1'b0;
        m_state = S_RUN;
        m_busy  = 1'b0;
        m_edges = 0;
        m_wait  = 0;
    endfunction

    // One rising edge of the reference: inputs are those held just before the edge.
    function automatic void modelEdge();
        bit     tick;
        longint tv;
        longint eff;
        longint nxt;
        int     ns;
        tick = ((m_edges % TICK) == TICK - 1);
        tv   = {32'b0, target_on_in};
        if (tv > MAX_ON) tv = MAX_ON;
        eff  = enable_in ? tv : 0;
        nxt  = m_cur;
        ns   = m_state;
        m_edges++;
        case (m_state)
            S_RUN: begin
                if (tick) nxt = towards(m_cur, eff);
                if (target_dir_in != m_dir) begin
                    if (m_cur != 0) begin
                        ns = S_DECEL;
                    end else begin
                        ns = S_WAIT;
                        nxt = 0;
                        m_wait = 0;
                    end
                end
            end
            S_DECEL: begin
                if (tick) nxt = towards(m_cur, 0);
                if (target_dir_in == m_dir) begin
                    ns = S_RUN;
                end else if (m_cur == 0) begin
                    ns = S_WAIT;
                    m_wait = 0;
                end
            end
            S_WAIT: begin
                nxt = 0;
                if (target_dir_in == m_dir) begin
                    ns = S_RUN;
                end else if (!motor_is_running) begin
                    m_dir = target_dir_in;
                    ns = S_RUN;
                end else begin
                    m_wait++;
                    if (m_wait >= STOP) ns = S_FAULT;
                end
            end
            default: begin
                nxt = 0;
                if (!enable_in) ns = S_RUN;
            end
        endcase
        m_cur   = nxt;
        m_state = ns;
        m_busy  = (ns != S_RUN) || (nxt != eff);
    endfunction

    task automatic stepClock();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(logic [31:0] t, bit d, bit e, bit r);
        target_on_in     = t;
        target_dir_in    = d;
        enable_in        = e;
        motor_is_running = r;
    endtask

    task automatic checkOutput(string name, longint on, int st, bit dout, bit b, bit f);
        cmp(name, "on_time_out", {32'b0, on_time_out}, on);
        cmp(name, "state_out", longint'(state_out), st);
        cmp(name, "motor_dir_out", longint'(motor_dir_out), longint'(dout));
        cmp(name, "busy_out", longint'(busy_out), longint'(b));
        cmp(name, "fault_out", longint'(fault_out), longint'(f));
    endtask

    task automatic checkModel(string name);
        checkOutput(name, m_cur, m_state, m_dir, m_busy, m_state == S_FAULT);
    endtask

    task automatic checkReached(string name, bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("[TB] FAIL %s condition got 0 expected 1 within cycle budget", name);
        end
    endtask

    initial begin
        logic [31:0] rt;
        bit          rd;
        bit          re;
        bit          rr;
        int          n;

        applyStimulus(32'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 0, S_RUN, 1'b0, 1'b0, 1'b0);
        #4 reset = 1'b1;

        // Ramp up and clamp, reversal, stop timeout, partial step, reversal abort.
        addVec(32'd5000, 0, 1, 1,  4,  100, S_RUN,   0, 1, 0);
        addVec(32'd5000, 0, 1, 1,  4,  200, S_RUN,   0, 1, 0);
        addVec(32'd5000, 0, 1, 1, 32, 1000, S_RUN,   0, 0, 0);
        addVec(32'd5000, 0, 1, 1,  8, 1000, S_RUN,   0, 0, 0);
        addVec(32'd5000, 1, 1, 1,  1, 1000, S_DECEL, 0, 1, 0);
        addVec(32'd5000, 1, 1, 1,  3,  900, S_DECEL, 0, 1, 0);
        addVec(32'd5000, 1, 1, 1, 36,    0, S_DECEL, 0, 1, 0);
        addVec(32'd5000, 1, 1, 1,  1,    0, S_WAIT,  0, 1, 0);
        addVec(32'd5000, 1, 1, 0,  1,    0, S_RUN,   1, 1, 0);
        addVec(32'd5000, 1, 1, 1,  2,  100, S_RUN,   1, 1, 0);
        addVec(32'd5000, 1, 1, 1, 36, 1000, S_RUN,   1, 0, 0);
        addVec(32'd5000, 0, 1, 1,  1, 1000, S_DECEL, 1, 1, 0);
        addVec(32'd5000, 0, 1, 1, 39,    0, S_DECEL, 1, 1, 0);
        addVec(32'd5000, 0, 1, 1,  1,    0, S_WAIT,  1, 1, 0);
        addVec(32'd5000, 0, 1, 1, 49,    0, S_WAIT,  1, 1, 0);
        addVec(32'd5000, 0, 1, 1,  1,    0, S_FAULT, 1, 1, 1);
        addVec(32'd5000, 0, 1, 1,  5,    0, S_FAULT, 1, 1, 1);
        addVec(32'd5000, 0, 0, 1,  1,    0, S_RUN,   1, 0, 0);
        addVec(32'd5000, 0, 0, 0,  2,    0, S_RUN,   0, 0, 0);
        addVec(32'd250,  0, 1, 1,  1,  100, S_RUN,   0, 1, 0);
        addVec(32'd250,  0, 1, 1,  4,  200, S_RUN,   0, 1, 0);
        addVec(32'd250,  0, 1, 1,  4,  250, S_RUN,   0, 0, 0);
        addVec(32'd250,  0, 1, 1,  4,  250, S_RUN,   0, 0, 0);
        addVec(32'd0,    0, 1, 1,  4,  150, S_RUN,   0, 1, 0);
        addVec(32'd0,    0, 1, 1,  4,   50, S_RUN,   0, 1, 0);
        addVec(32'd0,    0, 1, 1,  4,    0, S_RUN,   0, 0, 0);
        addVec(32'd1000, 0, 1, 1, 24,  600, S_RUN,   0, 1, 0);
        addVec(32'd1000, 1, 1, 1,  1,  600, S_DECEL, 0, 1, 0);
        addVec(32'd1000, 1, 1, 1,  7,  400, S_DECEL, 0, 1, 0);
        addVec(32'd1000, 0, 1, 1,  1,  400, S_RUN,   0, 1, 0);
        addVec(32'd1000, 0, 1, 1,  3,  500, S_RUN,   0, 1, 0);
        addVec(32'd1000, 0, 1, 1, 20, 1000, S_RUN,   0, 0, 0);
        addVec(32'hFFFF_FFFF, 0, 1, 1, 8, 1000, S_RUN, 0, 0, 0);
        addVec(32'hFFFF_FFFF, 0, 0, 1, 4,  900, S_RUN, 0, 1, 0);
        addVec(32'd1000, 0, 1, 1,  4, 1000, S_RUN,   0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].target, vecs[i].dir, vecs[i].en, vecs[i].run);
            repeat (vecs[i].cycles) stepClock();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_on, vecs[i].exp_state,
                        vecs[i].exp_dir, vecs[i].exp_busy, vecs[i].exp_fault);
        end

        // Full reversal with the motor already stopped, so direction flips to 1.
        applyStimulus(32'd1000, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!(motor_dir_out == 1'b1 && state_out == 2'd0) && n < 200) begin
            stepClock();
            checkModel("rev_flip");
            n++;
        end
        checkReached("rev_flip_reached", motor_dir_out == 1'b1 && state_out == 2'd0);

        applyStimulus(32'd1000, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (on_time_out != 32'd1000 && n < 200) begin
            stepClock();
            checkModel("rev_climb");
            n++;
        end
        checkReached("rev_climb_reached", on_time_out == 32'd1000);

        // Reverse again and assert reset asynchronously mid-deceleration at 300.
        applyStimulus(32'd1000, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (on_time_out != 32'd300 && n < 200) begin
            stepClock();
            checkModel("decel_to_300");
            n++;
        end
        checkReached("decel_300_reached", on_time_out == 32'd300 && state_out == 2'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset", 0, S_RUN, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 0, S_RUN, 1'b0, 1'b0, 1'b0);
        #4 reset = 1'b1;
        repeat (3) stepClock();
        checkOutput("first_tick_pending", 0, S_RUN, 1'b0, 1'b1, 1'b0);
        stepClock();
        checkOutput("first_tick", 100, S_RUN, 1'b0, 1'b1, 1'b0);

        // Random phase against the behavioural model.
        rt = 32'd1000;
        rd = 1'b0;
        re = 1'b1;
        rr = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: rt = $urandom_range(0, 1200);
                    1: rt = $urandom;
                    2: rt = 32'd0;
                    default: rt = 32'hFFFF_FFFF;
                endcase
            end
            if ($urandom_range(0, 59) == 0) rd = ~rd;
            if ($urandom_range(0, 89) == 0) re = ~re;
            if ($urandom_range(0, 39) == 0) rr = ~rr;
            applyStimulus(rt, rd, re, rr);
            stepClock();
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

Soft-start and direction-reversal controller placed between the MicroBlaze register interface and the motor driver datapath. It drives the PWM generator's on-time input and the direction controller's direction input. It ramps the on-time toward the processor set point in bounded steps. Before a direction reversal, it ramps to zero and waits for the encoder to report the motor stopped. A stall during the stop wait is flagged as a fault.

## Interface
- `CLOCK_FREQ_HZ`, 100000000, system clock frequency (documentation only; timing is in cycles).
- `MAX_ON_TIME`, 10000, on-time clamp in clocks; equals one PWM period at 10 kHz.
- `RAMP_STEP`, 50, maximum on-time change per ramp tick.
- `RAMP_TICK_CYCLES`, 100000, clocks between ramp ticks; must be ≥ 2.
- `STOP_TIMEOUT_CYCLES`, 50000000, maximum clocks spent in WAIT_STOP before a fault.
- `clk`, in, 1, system clock; all logic is on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `target_on_in`, in, 32, requested on-time from the processor.
- `target_dir_in`, in, 1, requested direction from the processor.
- `enable_in`, in, 1, motor enable switch; low forces the effective target to 0.
- `motor_is_running`, in, 1, encoder activity indication from the encoder detection block.
- `on_time_out`, out, 32, registered on-time to the PWM generator.
- `motor_dir_out`, out, 1, registered direction to the direction controller.
- `state_out`, out, 2, current state: RUN=0, DECEL=1, WAIT_STOP=2, FAULT=3.
- `busy_out`, out, 1, high while a transition or ramp is in progress.
- `fault_out`, out, 1, high in FAULT (stop timeout).

## Operation
- Clamp: `tgt = min(target_on_in, MAX_ON_TIME)`, compared as unsigned 32-bit.
- Effective target: `eff = enable_in ? tgt : 0`.
- Tick prescaler:
  - Free-running counter produces a 1-cycle `tick` every RAMP_TICK_CYCLES clocks.
  - The first tick comes RAMP_TICK_CYCLES clocks after reset deassertion.
- Ramp rule, on a tick only:
  - If `cur < goal`: `cur += min(RAMP_STEP, goal-cur)`.
  - If `cur > goal`: `cur -= min(RAMP_STEP, cur-goal)`.
  - Never overshoots; no wrap. Evaluate the differences before adding, so there is no 32-bit overflow.
- RUN:
  - `goal = eff`.
  - If `target_dir_in != motor_dir_out`: go to DECEL if `cur != 0`, otherwise go to WAIT_STOP.
- DECEL:
  - `goal = 0`.
  - If `target_dir_in` returns to `motor_dir_out`, go to RUN; the ramp resumes from `cur`.
  - When `cur == 0`, go to WAIT_STOP and clear the timeout counter.
- WAIT_STOP (`cur` held at 0):
  - If `target_dir_in == motor_dir_out`, go to RUN with no flip.
  - Else if `motor_is_running == 0`, set `motor_dir_out <= target_dir_in` and go to RUN.
  - Else, if the timeout counter reaches STOP_TIMEOUT_CYCLES-1, go to FAULT.
- FAULT:
  - `cur` forced to 0 on entry; `fault_out = 1`.
  - Leave to RUN only when `enable_in == 0` is sampled; direction is left unchanged.
- `busy_out = (state != RUN) | (cur != eff)`.
- Simultaneous events:
  - A direction mismatch takes priority over ramping in RUN: the state changes that cycle, and the tick in that same cycle still applies with `goal = eff`.
  - In WAIT_STOP, the direction-revert check precedes the stop check, which precedes the timeout.

## Timing
- Reset values: `on_time_out = 0`, `motor_dir_out = 0`, `state_out = 0` (RUN), `busy_out = 0`, `fault_out = 0`; prescaler and timeout counters are 0.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous).
- `on_time_out` changes on the clock edge after the tick cycle (1-cycle latency).
- State transitions take effect on the edge following the qualifying condition.
- `state_out` and `fault_out` are registered and update on that same edge.
- `motor_dir_out` flips on the same edge as WAIT_STOP → RUN.
  - `on_time_out` is 0 on that edge and for at least the first tick after it.
  - A nonzero on-time never coexists with a direction change.
- `target_on_in` changes take effect at the next tick; no handshake is required.
- The minimum reversal time is `ceil(cur/RAMP_STEP)` ticks plus one cycle of WAIT_STOP.

## Test plan
All scenarios use `MAX_ON_TIME=1000`, `RAMP_STEP=100`, `RAMP_TICK_CYCLES=4`, `STOP_TIMEOUT_CYCLES=50`.

- **Ramp up and clamp.** Set `enable_in=1`, `target_on_in=5000` → `on_time_out` goes 100, 200, …, 1000, one step per 4 clocks, then holds at 1000; `busy_out` drops after 1000 is reached.
- **Partial step and ramp down.** Target 250 from 0 → 100, 200, 250. Then target 0 → 150, 50, 0. No overshoot at any point.
- **Reversal.** At `cur=1000`, toggle `target_dir_in`:
  - State goes to DECEL and ramps to 0 in 10 ticks, then WAIT_STOP.
  - Drop `motor_is_running` → `motor_dir_out` flips and state returns to RUN.
  - The ramp then climbs back to 1000.
- **Stop timeout.** Hold `motor_is_running=1` in WAIT_STOP → FAULT after 50 clocks with `fault_out=1` and `on_time_out=0`. Pulse `enable_in=0` → RUN, `fault_out=0`.
- **Reversal abort.** Toggle `target_dir_in` in DECEL at `cur=600`, then toggle it back at `cur=400` → state returns to RUN, the ramp climbs from 400, and direction never changes.
- **Reset mid-ramp.** Assert `reset=0` asynchronously at `cur=300` during DECEL → all outputs read 0 / RUN before the next clock edge.
